// File: rtl/fuec_rd_pkg.sv
// Shared widths, scrub-entry layout and position encoder for the FUEC(12,8) read path.
package fuec_rd_pkg;

    localparam int FUEC_DATA_W = 8;
    localparam int FUEC_POS_W  = 3;
    localparam int FUEC_ADDR_W = 10;

    typedef struct packed {
        logic [FUEC_ADDR_W-1:0] addr;
        logic [FUEC_DATA_W-1:0] data;
    } scrub_entry_t;

    // Iterating from the top down leaves the lowest set bit as the result.
    function automatic logic [FUEC_POS_W-1:0] onehot_to_idx(input logic [FUEC_DATA_W-1:0] onehot);
        logic [FUEC_POS_W-1:0] idx;
        idx = '0;
        for (int i = FUEC_DATA_W - 1; i >= 0; i--) begin
            if (onehot[i]) idx = FUEC_POS_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fuec_rd_scrub_ctrl_fifo.sv
// Scrub write-back queue: circular buffer with wrapping pointers and an occupancy count.
module fuec_wb_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    // A pop in the same cycle frees the slot a push into a full queue needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fuec_rd_scrub_ctrl.sv
// Read-path stage after the FUEC decoder: registered output beat, scrub queueing and error statistics.
module fuec_rd_scrub_ctrl
    import fuec_rd_pkg::*;
#(
    parameter int ADDR_W   = FUEC_ADDR_W,
    parameter int WB_DEPTH = 2,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [FUEC_DATA_W-1:0] data_dec,
    input  logic [FUEC_DATA_W-1:0] pos_error,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [FUEC_DATA_W-1:0] out_data,
    output logic                   out_corr,
    output logic [FUEC_POS_W-1:0]  out_pos,
    input  logic                   scrub_en,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [ADDR_W-1:0]      wb_addr,
    output logic [FUEC_DATA_W-1:0] wb_data,
    input  logic                   clr_stats,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic [ADDR_W-1:0]      last_err_addr,
    output logic [FUEC_POS_W-1:0]  last_err_pos,
    output logic                   wb_ovf
);

    // Same {addr, data} layout as scrub_entry_t, sized by this instance's ADDR_W.
    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic [FUEC_DATA_W-1:0] data;
    } wb_entry_t;

    logic                  out_valid_q;
    logic [ADDR_W-1:0]     out_addr_q;
    logic [FUEC_DATA_W-1:0] out_data_q;
    logic                  out_corr_q;
    logic [FUEC_POS_W-1:0] out_pos_q;
    logic [CNT_W-1:0]      err_cnt_q, drop_cnt_q;
    logic [ADDR_W-1:0]     last_err_addr_q;
    logic [FUEC_POS_W-1:0] last_err_pos_q;
    logic                  wb_ovf_q;

    logic                  accept, beat_corr, corr_beat, push_req, pop, drop;
    logic                  fifo_full, fifo_empty;
    logic [FUEC_POS_W-1:0] beat_pos;
    wb_entry_t             push_entry, head_entry;

    assign in_ready   = ~out_valid_q | out_ready;
    assign accept     = in_valid & in_ready;
    assign beat_corr  = |pos_error;
    assign beat_pos   = onehot_to_idx(pos_error);
    assign corr_beat  = accept & beat_corr;
    assign push_req   = corr_beat & scrub_en;
    assign pop        = wb_valid & wb_ready;
    assign drop       = push_req & fifo_full & ~pop;
    assign push_entry = '{addr: in_addr, data: data_dec};

    fuec_wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (WB_DEPTH)
    ) u_wb_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wb_valid = ~fifo_empty;
    assign wb_addr  = head_entry.addr;
    assign wb_data  = head_entry.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_corr_q  <= 1'b0;
            out_pos_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_addr_q  <= in_addr;
            out_data_q  <= data_dec;
            out_corr_q  <= beat_corr;
            out_pos_q   <= beat_pos;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Clear has priority over a same-cycle increment or drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
            wb_ovf_q   <= 1'b0;
        end else if (clr_stats) begin
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
            wb_ovf_q   <= 1'b0;
        end else begin
            if (corr_beat && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            if (drop && drop_cnt_q != '1)     drop_cnt_q <= drop_cnt_q + 1'b1;
            if (drop)                         wb_ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_err_addr_q <= '0;
            last_err_pos_q  <= '0;
        end else if (corr_beat) begin
            last_err_addr_q <= in_addr;
            last_err_pos_q  <= beat_pos;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_addr      = out_addr_q;
    assign out_data      = out_data_q;
    assign out_corr      = out_corr_q;
    assign out_pos       = out_pos_q;
    assign err_cnt       = err_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign last_err_addr = last_err_addr_q;
    assign last_err_pos  = last_err_pos_q;
    assign wb_ovf        = wb_ovf_q;

endmodule

// File: doc/fuec_rd_scrub_ctrl.md
Name: fuec_rd_scrub_ctrl

Overview:
Sequential read-path stage directly downstream of the FUEC(12,8) decoder interface. It consumes the decoder's corrected byte (data_dec) and one-hot error-position vector (pos_error) per read beat. It registers each beat onto a valid/ready output stream with the error position encoded. It also queues write-back (scrub) requests of the corrected byte into a small FIFO and keeps saturating error and drop statistics.

Parameters:
ADDR_W, 10, read/write-back address width
WB_DEPTH, 2, scrub FIFO depth; power of two, >=2
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  read beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
in_addr  in  ADDR_W  address of the read beat
data_dec  in  8  corrected data byte from the decoder
pos_error  in  8  one-hot corrected-bit position; 0 = no data-bit correction
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_addr  out  ADDR_W  registered in_addr
out_data  out  8  registered data_dec
out_corr  out  1  |pos_error of the beat
out_pos  out  3  binary index of the set pos_error bit; 0 when out_corr=0
scrub_en  in  1  enables write-back queueing
wb_valid  out  1  scrub request pending (FIFO not empty)
wb_ready  in  1  memory accepts the scrub write
wb_addr  out  ADDR_W  FIFO-head address
wb_data  out  8  FIFO-head corrected byte
clr_stats  in  1  synchronous clear of statistics and sticky flag
err_cnt  out  CNT_W  corrected beats, saturating
drop_cnt  out  CNT_W  scrub requests lost to a full FIFO, saturating
last_err_addr  out  ADDR_W  address of the most recent corrected beat
last_err_pos  out  3  position of the most recent correction
wb_ovf  out  1  sticky: at least one scrub request dropped

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_addr/out_data/out_pos=0, out_corr=0. FIFO empty, so wb_valid=0 and wb_addr/wb_data=0. err_cnt=drop_cnt=0, last_err_*=0, wb_ovf=0. Reset mid-transfer discards the output beat and all queued scrubs.
- Output pipeline: a single register stage. in_ready = !out_valid | out_ready (combinational). Latency is 1 cycle from accept to out_valid. The output holds stable while out_valid & !out_ready. Accepting and draining in the same cycle sustains 1 beat/cycle.
- Position encode: out_pos = index of the set bit of pos_error. pos_error is one-hot or zero by construction. If more than one bit is set, the lowest index wins and the beat counts as corrected.
- A corrected beat is an accepted beat with |pos_error=1. On each corrected beat:
  - err_cnt increments and saturates at 2^CNT_W-1.
  - last_err_addr and last_err_pos load the beat's address and position.
  - If scrub_en=1, push {in_addr, data_dec} into the FIFO.
- A push when the FIFO is full and there is no simultaneous pop drops the request. drop_cnt increments (saturating) and wb_ovf is set.
- Push and pop in the same cycle while full: the pop frees a slot, the push succeeds, and the count is unchanged.
- With scrub_en=0, no push occurs and no drop is counted.
- FIFO: circular buffer with read and write pointers of log2(WB_DEPTH) bits that wrap modulo WB_DEPTH, plus an occupancy count. wb_valid = count != 0. A pop occurs on wb_valid & wb_ready. wb_addr/wb_data show the head entry and stay stable until popped. Order is FIFO.
- Push into an empty FIFO: wb_valid rises the next cycle, with no bypass.
- clr_stats: next cycle err_cnt=0, drop_cnt=0, wb_ovf=0. Clear wins over a same-cycle increment or drop. last_err_* and the FIFO are not affected.
- Beats with pos_error=0 pass through with out_corr=0 and out_pos=0, and touch no statistics.

Decomposition:
- Package fuec_rd_pkg: FUEC_DATA_W=8, FUEC_POS_W=3, the scrub-entry struct {addr, data}, and a function onehot_to_idx(8)->3 (lowest bit wins).
- Sub-module fuec_wb_fifo (parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty) implements the scrub queue.
- Output register, encoder and statistics stay in the top.

Test Plan:
- Clean beat: in_addr=0x005, data_dec=0xA5, pos_error=0x00, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_corr=0, out_pos=0, err_cnt=0, wb_valid=0.
- Corrected beat with scrub: scrub_en=1, addr 0x010, data 0x3C, pos_error=0x08 -> out_corr=1, out_pos=3, err_cnt=1, last_err_addr=0x010, last_err_pos=3; wb_valid=1 next cycle with wb_addr=0x010, wb_data=0x3C.
- Overflow: wb_ready=0, WB_DEPTH=2, three corrected beats to addresses 1, 2, 3 -> FIFO holds 1 and 2, drop_cnt=1, wb_ovf=1. Raise wb_ready -> pops in order 1, 2, then wb_valid=0.
- Full with simultaneous pop+push: FIFO full, wb_ready=1, corrected beat to addr 7 in the same cycle -> no drop, drop_cnt unchanged, head order 2, 7.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0 and outputs hold. Release -> the pending beat is accepted the same cycle and appears next cycle.
- Saturation and clear: CNT_W=4, 16 corrected beats -> err_cnt=15. Pulse clr_stats together with one more corrected beat -> err_cnt=0, wb_ovf=0, last_err_* updated to that beat.
